// File: rtl/key_pkg.sv
// Shared definitions for the key gesture classifier:
// FSM state encoding and default cycle thresholds for a 50 MHz clock.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } key_state_e;

    localparam int unsigned KEY_LONG_CYC   = 50_000_000;
    localparam int unsigned KEY_REPEAT_CYC = 10_000_000;
    localparam int unsigned KEY_DCLICK_CYC = 15_000_000;
    localparam int unsigned KEY_CNT_W      = 32;

endpackage

// File: rtl/key_edge.sv
// Edge detector for the debounced, active-low key level.
// Ports: clk, rst_n (async active-low), key_level in;
//        fall/rise (combinational, this cycle), pressed (registered ~key_level) out.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    output logic fall,
    output logic rise,
    output logic pressed
);

    logic prev_q, prev_d;
    logic pressed_q, pressed_d;

    always_comb begin
        prev_d    = key_level;
        pressed_d = ~key_level;
    end

    // prev resets to 0 so a key held through reset never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pressed_q <= pressed_d;
        end
    end

    assign fall    = prev_q & ~key_level;
    assign rise    = ~prev_q & key_level;
    assign pressed = pressed_q;

endmodule

// File: rtl/key_event.sv
// Classifies key gestures into one-cycle pulses: short, double, long, repeat.
// Ports: clk, rst_n (async active-low), key_level (0 = pressed) in;
//        short_pulse, double_pulse, long_pulse, repeat_pulse, pressed out (all registered).
module key_event
    import key_pkg::*;
#(
    parameter int unsigned LONG_CYC   = KEY_LONG_CYC,
    parameter int unsigned REPEAT_CYC = KEY_REPEAT_CYC,
    parameter int unsigned DCLICK_CYC = KEY_DCLICK_CYC,
    parameter int unsigned CNT_W      = KEY_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic pressed
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYC - 1);

    logic fall;
    logic rise;

    key_edge u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_level (key_level),
        .fall      (fall),
        .rise      (rise),
        .pressed   (pressed)
    );

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             rep_clr;

    // Edges are tested before terminal counts so an edge
    // landing on the timeout cycle wins and the pulse is dropped.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        rep_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) state_d = PRESS1;
            end
            PRESS1: begin
                if (rise) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            WAIT2: begin
                if (fall) begin
                    state_d = PRESS2;
                end else if (cnt_q == DCLICK_TC) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (rise) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == LONG_TC) begin
                    // First click is reported as a short press.
                    short_d = 1'b1;
                    long_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rise) begin
                    state_d = IDLE;
                end else if (cnt_q == REPEAT_TC) begin
                    repeat_d = 1'b1;
                    rep_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // IDLE has no terminal count, so the counter is parked
        // there to keep it from ever wrapping.
        if (state_d != state_q || rep_clr || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign short_pulse  = short_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_key_event.sv
// Directed self-checking bench for key_event (LONG=20, REPEAT=5, DCLICK=10).
// Observed vector per cycle: {short, double, long, repeat, pressed}.
module tb_key_event;
    import key_pkg::*;

    logic clk;
    logic rst_n;
    logic key_level;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic pressed;
    logic [4:0] obs;

    int checks;
    int errors;

    key_event #(
        .LONG_CYC   (20),
        .REPEAT_CYC (5),
        .DCLICK_CYC (10),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_level    (key_level),
        .short_pulse  (short_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .pressed      (pressed)
    );

    assign obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, pressed};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        key_level = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst_n     = 1'b0;
        key_level = 1'b1;
        repeat (3) step();
        exp = 5'b00000;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, exp);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE);
        end
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_short();
        logic [4:0] exp;
        settle();
        for (int t = 1; t <= 30; t++) begin
            key_level = (t <= 5) ? 1'b0 : 1'b1;
            step();
            exp = {(t == 16), 1'b0, 1'b0, 1'b0, (t <= 5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL short t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_double();
        logic [4:0] exp;
        logic       k;
        settle();
        for (int t = 1; t <= 30; t++) begin
            k = !((t <= 4) || (t >= 8 && t <= 11));
            key_level = k;
            step();
            exp = {1'b0, (t == 12), 1'b0, 1'b0, !k};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL double t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [4:0] exp;
        logic       rep;
        settle();
        for (int t = 1; t <= 60; t++) begin
            key_level = (t <= 41) ? 1'b0 : 1'b1;
            step();
            rep = (t == 26) || (t == 31) || (t == 36) || (t == 41);
            exp = {1'b0, 1'b0, (t == 21), rep, (t <= 41)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_repeat t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    // Release lands on the first repeat terminal count (edge 32): no repeat.
    task automatic test_long_second();
        logic [4:0] exp;
        logic       k;
        settle();
        for (int t = 1; t <= 45; t++) begin
            k = !((t <= 3) || (t >= 7 && t <= 31));
            key_level = k;
            step();
            exp = {(t == 27), 1'b0, (t == 27), 1'b0, !k};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_second t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    // Second press sampled on the WAIT2 timeout edge (cnt=9).
    task automatic test_edge_beats_timeout();
        logic [4:0] exp;
        logic       k;
        settle();
        for (int t = 1; t <= 30; t++) begin
            k = !((t <= 3) || (t >= 14 && t <= 16));
            key_level = k;
            step();
            exp = {1'b0, (t == 17), 1'b0, 1'b0, !k};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL edge_timeout t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        logic       k;
        settle();
        for (int t = 1; t <= 10; t++) begin
            key_level = 1'b0;
            step();
        end
        rst_n = 1'b0;
        #1;
        exp = 5'b00000;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_outputs got=%b exp=%b", obs, exp);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_mid_state got=%0d exp=%0d", dut.state_q, IDLE);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int t = 1; t <= 55; t++) begin
            k = !((t <= 25) || (t >= 28 && t <= 48));
            key_level = k;
            step();
            exp = {1'b0, 1'b0, (t == 48), 1'b0, !k};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL held_reset t=%0d got=%b exp=%b", t, obs, exp);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        key_level = 1'b1;
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_long_second();
        test_edge_beats_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
